// File: rtl/frame_buffer_pkg.sv
// Shared types and constants for the ping-pong frame buffer scheduler.
package frame_buffer_pkg;

    localparam int DEF_H_WIDTH = 320;
    localparam int DEF_V_WIDTH = 240;

    localparam int RX_IDLE_BIT       = 0;
    localparam int RX_FRAME_DONE_BIT = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_PENDING = 3'd2,
        S_NEXT    = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;

endpackage

// File: rtl/edge_detector_n.sv
// Registered N-bit rising-edge detector; o_rise is high the cycle after a 0->1 input change.
module edge_detector_n #(
    parameter int N = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_sig,
    output logic [N-1:0] o_rise
);

    logic [N-1:0] prev_q, prev_d;
    logic [N-1:0] rise_q, rise_d;

    always_comb begin
        prev_d = i_sig;
        rise_d = i_sig & ~prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_q <= '0;
            rise_q <= '0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Sequences the OV7670 receiver and swaps a ping-pong frame buffer on display vsync.
// Optional macro SWAP_TIMEOUT_EN forces a swap if vsync stalls for SWAP_TIMEOUT cycles.
module frame_buffer_scheduler
    import frame_buffer_pkg::*;
#(
    parameter int H_WIDTH      = DEF_H_WIDTH,
    parameter int V_WIDTH      = DEF_V_WIDTH,
    parameter int PXL_WIDTH    = 16,
    parameter int ADDR_WIDTH   = $clog2(H_WIDTH * V_WIDTH),
    parameter int SWAP_TIMEOUT = 2_000_000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_freeze,
    input  logic [5:0]                 i_rx_state,
    input  logic                       i_rx_valid,
    input  logic [$clog2(H_WIDTH)-1:0] i_rx_h_addr,
    input  logic [$clog2(V_WIDTH)-1:0] i_rx_v_addr,
    input  logic [PXL_WIDTH-1:0]       i_rx_pixel,
    input  logic                       i_disp_vsync,
    output logic                       o_start_capture,
    output logic                       o_next_frame,
    output logic                       o_wr_en,
    output logic [ADDR_WIDTH:0]        o_wr_addr,
    output logic [PXL_WIDTH-1:0]       o_wr_data,
    output logic                       o_rd_bank,
    output logic [15:0]                o_frame_cnt,
    output logic                       o_overflow,
`ifdef SWAP_TIMEOUT_EN
    output logic                       o_swap_timeout,
`endif
    output logic [2:0]                 o_state
);

    state_t                state_q, state_d;
    logic                  armed_q, armed_d;
    logic                  pend_armed_q, pend_armed_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  start_q, start_d;
    logic                  next_q, next_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH:0]   wr_addr_q, wr_addr_d;
    logic [PXL_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                  overflow_q, overflow_d;
    logic                  vs_rise;
    logic                  swap;
    logic                  wr_ok;
    logic                  in_range;
    logic [31:0]           addr_full;
    logic                  frame_done;

`ifdef SWAP_TIMEOUT_EN
    localparam int TMO_W = (SWAP_TIMEOUT > 1) ? $clog2(SWAP_TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             swap_tmo_q, swap_tmo_d;
`endif

    logic unused_bits;
    assign unused_bits = ^{i_rx_state[4:0], addr_full[31:ADDR_WIDTH]};

    edge_detector_n #(.N(1)) u_vsync_edge (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_sig  (i_disp_vsync),
        .o_rise (vs_rise)
    );

    assign frame_done = i_rx_state[RX_FRAME_DONE_BIT];

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        pend_armed_d = pend_armed_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        frame_cnt_d  = frame_cnt_q;
        start_d      = 1'b0;
        next_d       = 1'b0;
        swap         = 1'b0;
`ifdef SWAP_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        swap_tmo_d   = swap_tmo_q;
`endif

        if (state_q == S_CAPTURE && !frame_done) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    start_d = 1'b1;
                    armed_d = 1'b0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (armed_q && frame_done) begin
                    state_d      = i_freeze ? S_NEXT : S_PENDING;
                    pend_armed_d = 1'b0;
`ifdef SWAP_TIMEOUT_EN
                    tmo_cnt_d    = TMO_W'(SWAP_TIMEOUT - 1);
`endif
                end
            end
            S_PENDING: begin
                // a rise coincident with entry belongs to the frame still on screen
                pend_armed_d = 1'b1;
                if (pend_armed_q && vs_rise) begin
                    swap = 1'b1;
`ifdef SWAP_TIMEOUT_EN
                end else if (tmo_cnt_q == '0) begin
                    swap       = 1'b1;
                    swap_tmo_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
`endif
                end
                if (swap) begin
                    wr_bank_d   = ~wr_bank_q;
                    rd_bank_d   = wr_bank_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_NEXT;
                end
            end
            S_NEXT, S_PAUSE: begin
                if (i_enable) begin
                    next_d  = 1'b1;
                    armed_d = 1'b0;
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        addr_full  = 32'(i_rx_v_addr) * 32'(H_WIDTH) + 32'(i_rx_h_addr);
        in_range   = (32'(i_rx_h_addr) < 32'(H_WIDTH)) && (32'(i_rx_v_addr) < 32'(V_WIDTH));
        wr_ok      = i_rx_valid && (state_q == S_CAPTURE) && armed_q;
        wr_en_d    = wr_ok && in_range;
        overflow_d = overflow_q | (wr_ok && !in_range);
        wr_addr_d  = {wr_bank_q, addr_full[ADDR_WIDTH-1:0]};
        wr_data_d  = i_rx_pixel;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            armed_q      <= 1'b0;
            pend_armed_q <= 1'b0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
            frame_cnt_q  <= '0;
            start_q      <= 1'b0;
            next_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            overflow_q   <= 1'b0;
`ifdef SWAP_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            swap_tmo_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            pend_armed_q <= pend_armed_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            frame_cnt_q  <= frame_cnt_d;
            start_q      <= start_d;
            next_q       <= next_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            overflow_q   <= overflow_d;
`ifdef SWAP_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            swap_tmo_q   <= swap_tmo_d;
`endif
        end
    end

    assign o_start_capture = start_q;
    assign o_next_frame    = next_q;
    assign o_wr_en         = wr_en_q;
    assign o_wr_addr       = wr_addr_q;
    assign o_wr_data       = wr_data_q;
    assign o_rd_bank       = rd_bank_q;
    assign o_frame_cnt     = frame_cnt_q;
    assign o_overflow      = overflow_q;
    assign o_state         = state_q;
`ifdef SWAP_TIMEOUT_EN
    assign o_swap_timeout  = swap_tmo_q;
`endif

endmodule
